// File: rtl/nios2_dbg_pkg.sv
// Shared constants and types for the Nios II debug sysclk command path.
// Holds default widths, the packed command record and the IR opcodes.
// Other files pull these in with an import.
package nios2_dbg_pkg;

  localparam int IR_W_DEF    = 2;
  localparam int DR_W_DEF    = 38;
  localparam int ACT_BIT_DEF = 35;
  localparam int DEPTH_DEF   = 4;

  // IR opcodes seen by the OCI blocks
  localparam logic [IR_W_DEF-1:0] IR_OCIMEM    = 2'd0;
  localparam logic [IR_W_DEF-1:0] IR_TRACEMEM  = 2'd1;
  localparam logic [IR_W_DEF-1:0] IR_BREAK     = 2'd2;
  localparam logic [IR_W_DEF-1:0] IR_TRACECTRL = 2'd3;

  // One queued command at the default widths
  typedef struct packed {
    logic [IR_W_DEF-1:0] ir;
    logic [DR_W_DEF-1:0] data;
    logic                act;
  } cmd_t;

endpackage

// File: rtl/nios2_dbg_pulse_sync.sv
// Purpose: bring an async TCK-domain level into clk and emit one pulse per rising edge.
// Latency: pulse is high during the 3rd clk after the level is first sampled high.
// Backpressure: none; one pulse per high period regardless of downstream state.
module nios2_dbg_pulse_sync (
  input  logic clk,
  input  logic reset,
  input  logic lvl_i,
  output logic pulse_o
);

  // sync_q[0] is the metastability catcher; flops reset high so a level
  // already high when reset releases does not look like a fresh edge
  logic [2:0] sync_q;

  // three-stage shift of the incoming level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= 3'b111;
    else       sync_q <= {sync_q[1:0], lvl_i};
  end

  assign pulse_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/nios2_dbg_sysclk_cmdq.sv
// Purpose: sync update-IR/DR strobes, queue {ir, sr} commands, decode popped heads to one-hot strobes.
// Latency: udr rise -> cmd_valid after 3 clk; pop -> take_(no_)action strobe the following clk.
// Backpressure: head held while cmd_valid & ~cmd_ready; pushes to a full queue drop and set ovf.
// Optional NIOS2_DBG_DROP_CNT_EN adds a saturating 8-bit dropped-command counter.
module nios2_dbg_sysclk_cmdq
  import nios2_dbg_pkg::*;
#(
  parameter int IR_W    = IR_W_DEF,
  parameter int DR_W    = DR_W_DEF,
  parameter int ACT_BIT = ACT_BIT_DEF,
  parameter int DEPTH   = DEPTH_DEF
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   vs_uir,
  input  logic                   vs_udr,
  input  logic [IR_W-1:0]        ir_in,
  input  logic [DR_W-1:0]        sr,
  output logic                   cmd_valid,
  input  logic                   cmd_ready,
  output logic [IR_W-1:0]        cmd_ir,
  output logic [DR_W-1:0]        jdo,
  output logic                   cmd_act,
  output logic [(2**IR_W)-1:0]   take_action,
  output logic [(2**IR_W)-1:0]   take_no_action,
  output logic                   ovf,
  input  logic                   ovf_clr,
  output logic [7:0]             drop_cnt
);

  localparam int NS = 2**IR_W;
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic uir_pulse;
  logic udr_pulse;

  nios2_dbg_pulse_sync u_uir_sync (.clk(clk), .reset(reset), .lvl_i(vs_uir), .pulse_o(uir_pulse));
  nios2_dbg_pulse_sync u_udr_sync (.clk(clk), .reset(reset), .lvl_i(vs_udr), .pulse_o(udr_pulse));

  logic [IR_W-1:0] ir_q;
  logic [IR_W-1:0] push_ir;
  logic [IR_W-1:0] mem_ir_q  [DEPTH];
  logic [DR_W-1:0] mem_dat_q [DEPTH];
  logic [PW-1:0]   wr_q, rd_q;
  logic            empty, full, pop, push, drop;
  logic [NS-1:0]   ta_d, ta_q, tna_d, tna_q;
  logic            ovf_q;

  // capture IR on each update-IR
  always_ff @(posedge clk or posedge reset) begin
    if (reset)          ir_q <= '0;
    else if (uir_pulse) ir_q <= ir_in;
  end

  // a coincident update-IR is treated as having happened first
  assign push_ir = uir_pulse ? ir_in : ir_q;

  // extra pointer MSB distinguishes full from empty
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = ~empty & cmd_ready;
  assign push  = udr_pulse & (~full | pop);
  assign drop  = udr_pulse & full & ~pop;

  // queue storage; contents are don't-care until pushed, so no reset
  always_ff @(posedge clk) begin
    if (push) begin
      mem_ir_q[wr_q[AW-1:0]]  <= push_ir;
      mem_dat_q[wr_q[AW-1:0]] <= sr;
    end
  end

  // read/write pointers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      if (push) wr_q <= wr_q + PW'(1);
      if (pop)  rd_q <= rd_q + PW'(1);
    end
  end

  // head fields forced to zero when the queue is empty
  assign cmd_valid = ~empty;
  assign cmd_ir    = cmd_valid ? mem_ir_q[rd_q[AW-1:0]]  : '0;
  assign jdo       = cmd_valid ? mem_dat_q[rd_q[AW-1:0]] : '0;
  assign cmd_act   = jdo[ACT_BIT];

  // decode the command being popped into one-hot strobes
  always_comb begin
    ta_d  = '0;
    tna_d = '0;
    if (pop) begin
      if (cmd_act) ta_d[cmd_ir]  = 1'b1;
      else         tna_d[cmd_ir] = 1'b1;
    end
  end

  // strobes are registered so they appear the clk after the pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ta_q  <= '0;
      tna_q <= '0;
    end else begin
      ta_q  <= ta_d;
      tna_q <= tna_d;
    end
  end

  assign take_action    = ta_q;
  assign take_no_action = tna_q;

  // sticky overflow; a drop in the same clk as a clear keeps it set
  always_ff @(posedge clk or posedge reset) begin
    if (reset)        ovf_q <= 1'b0;
    else if (drop)    ovf_q <= 1'b1;
    else if (ovf_clr) ovf_q <= 1'b0;
  end

  assign ovf = ovf_q;

`ifdef NIOS2_DBG_DROP_CNT_EN
  logic [7:0] cnt_q;

  // saturating drop counter; clear+drop together restarts the count at 1
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 cnt_q <= '0;
    else if (drop && ovf_clr)  cnt_q <= 8'd1;
    else if (drop)             cnt_q <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
    else if (ovf_clr)          cnt_q <= '0;
  end

  assign drop_cnt = cnt_q;
`else
  assign drop_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_nios2_dbg_sysclk_cmdq.sv
module tb_nios2_dbg_sysclk_cmdq;
  import nios2_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        vs_uir, vs_udr, cmd_ready, ovf_clr;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_valid, cmd_act, ovf;
  logic [1:0]  cmd_ir;
  logic [37:0] jdo;
  logic [3:0]  take_action, take_no_action;
  logic [7:0]  drop_cnt;

  int errors = 0;
  int checks = 0;

  // reference model: queue contents, captured IR, overflow flag, drop count
  cmd_t mq[$];
  logic [1:0] m_ir;
  logic       m_ovf;
  int         m_cnt;

  always #5 clk = ~clk;

  nios2_dbg_sysclk_cmdq dut (
    .clk(clk), .reset(reset), .vs_uir(vs_uir), .vs_udr(vs_udr), .ir_in(ir_in), .sr(sr),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ir(cmd_ir), .jdo(jdo), .cmd_act(cmd_act),
    .take_action(take_action), .take_no_action(take_no_action), .ovf(ovf), .ovf_clr(ovf_clr),
    .drop_cnt(drop_cnt)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [37:0] rnd38();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[37:0];
  endfunction

  function automatic int exp_cnt();
`ifdef NIOS2_DBG_DROP_CNT_EN
    return m_cnt;
`else
    return 0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_push(input logic [37:0] d);
    cmd_t c;
    if (mq.size() < 4) begin
      c.ir = m_ir; c.data = d; c.act = d[35];
      mq.push_back(c);
    end else begin
      m_ovf = 1'b1;
      if (m_cnt < 255) m_cnt++;
    end
  endtask

  task automatic do_uir(input logic [1:0] ir);
    ir_in = ir; vs_uir = 1'b1;
    repeat (4) tick();
    vs_uir = 1'b0;
    repeat (2) tick();
    m_ir = ir;
  endtask

  task automatic do_udr(input logic [37:0] d);
    sr = d; vs_udr = 1'b1;
    repeat (4) tick();
    vs_udr = 1'b0;
    repeat (2) tick();
    model_push(d);
  endtask

  task automatic check_head(input string tag);
    chk({tag, "_valid"}, 64'(cmd_valid), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      chk({tag, "_ir"},  64'(cmd_ir),  64'(mq[0].ir));
      chk({tag, "_jdo"}, 64'(jdo),     64'(mq[0].data));
      chk({tag, "_act"}, 64'(cmd_act), 64'(mq[0].act));
    end
  endtask

  // strobe expected for a popped command: bit number ir in the matching vector
  task automatic check_strobe(input string tag, input cmd_t c);
    logic [3:0] onehot;
    onehot = 4'b0001 << c.ir;
    chk({tag, "_ta"},  64'(take_action),    64'(c.act ? onehot : 4'b0000));
    chk({tag, "_tna"}, 64'(take_no_action), 64'(c.act ? 4'b0000 : onehot));
  endtask

  task automatic pop_chk(input string tag);
    cmd_t c;
    check_head(tag);
    c = mq.pop_front();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    check_strobe(tag, c);
    tick();
    chk({tag, "_ta_off"},  64'(take_action),    64'h0);
    chk({tag, "_tna_off"}, 64'(take_no_action), 64'h0);
  endtask

  initial begin
    logic [37:0] d;
    logic [1:0]  r;
    int na_hits, a_hits;
    cmd_t c;

    reset = 1'b1; vs_uir = 0; vs_udr = 0; cmd_ready = 0; ovf_clr = 0; ir_in = 0; sr = 0;
    mq.delete(); m_ir = 0; m_ovf = 0; m_cnt = 0;
    repeat (2) tick();
    chk("rst_valid", 64'(cmd_valid), 64'h0);
    chk("rst_ta",    64'(take_action), 64'h0);
    chk("rst_tna",   64'(take_no_action), 64'h0);
    chk("rst_ovf",   64'(ovf), 64'h0);
    chk("rst_cnt",   64'(drop_cnt), 64'h0);
    reset = 1'b0;
    repeat (3) tick();
    chk("post_rst_valid", 64'(cmd_valid), 64'h0);

    // 1: IR=BREAK, action command; exact push latency then pop
    do_uir(IR_BREAK);
    d = rnd38(); d[35] = 1'b1;
    sr = d; vs_udr = 1'b1;
    tick(); tick();
    chk("t1_valid_before", 64'(cmd_valid), 64'h0);
    tick();
    chk("t1_valid_after", 64'(cmd_valid), 64'h1);
    tick(); vs_udr = 1'b0; repeat (2) tick();
    model_push(d);
    pop_chk("t1");

    // 2: no-action command with cmd_ready held high
    do_uir(IR_OCIMEM);
    d = rnd38(); d[35] = 1'b0;
    sr = d; cmd_ready = 1'b1; vs_udr = 1'b1;
    na_hits = 0; a_hits = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (i == 3) vs_udr = 1'b0;
      if (take_no_action == 4'b0001) na_hits++;
      if (take_action != 4'b0000) a_hits++;
    end
    cmd_ready = 1'b0;
    chk("t2_na_cycles", 64'(na_hits), 64'd1);
    chk("t2_a_cycles",  64'(a_hits),  64'd0);
    chk("t2_valid",     64'(cmd_valid), 64'h0);

    // 3: five pushes into a depth-4 queue, last one dropped
    do_uir(2'($urandom_range(0, 3)));
    for (int i = 0; i < 5; i++) do_udr(rnd38());
    chk("t3_ovf", 64'(ovf), 64'(m_ovf));
    chk("t3_cnt", 64'(drop_cnt), 64'(exp_cnt()));
    check_head("t3_head");

    // 4: push coincident with pop on a full queue is accepted
    d = rnd38(); sr = d; vs_udr = 1'b1;
    tick(); tick();
    check_head("t4_head");
    c = mq.pop_front();
    cmd_ready = 1'b1;
    tick();
    cmd_ready = 1'b0;
    model_push(d);
    check_strobe("t4", c);
    tick(); vs_udr = 1'b0; repeat (2) tick();
    chk("t4_ovf", 64'(ovf), 64'(m_ovf));
    chk("t4_cnt", 64'(drop_cnt), 64'(exp_cnt()));

    // 6: clear coinciding with a drop keeps ovf; clear alone resets it
    d = rnd38(); sr = d; vs_udr = 1'b1;
    tick(); tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    m_ovf = 1'b1; m_cnt = 1;
    chk("t6_ovf_set_wins", 64'(ovf), 64'h1);
    chk("t6_cnt_restart",  64'(drop_cnt), 64'(exp_cnt()));
    tick(); vs_udr = 1'b0; repeat (2) tick();
    ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
    m_ovf = 1'b0; m_cnt = 0;
    chk("t6_ovf_clr", 64'(ovf), 64'h0);
    chk("t6_cnt_clr", 64'(drop_cnt), 64'h0);

    // drain: occupancy must be exactly 4, in order
    for (int i = 0; i < 4; i++) pop_chk($sformatf("drain%0d", i));
    chk("drain_empty", 64'(cmd_valid), 64'h0);

    // pop on empty is ignored
    cmd_ready = 1'b1; repeat (2) tick(); cmd_ready = 1'b0;
    chk("empty_pop_ta",  64'(take_action), 64'h0);
    chk("empty_pop_tna", 64'(take_no_action), 64'h0);
    chk("empty_pop_valid", 64'(cmd_valid), 64'h0);

    // same-cycle update-IR and update-DR: pushed command uses the new IR
    r = (m_ir + 2'd1); d = rnd38();
    ir_in = r; sr = d; vs_uir = 1'b1; vs_udr = 1'b1;
    repeat (4) tick();
    vs_uir = 1'b0; vs_udr = 1'b0;
    repeat (2) tick();
    m_ir = r; model_push(d);
    pop_chk("same_cyc");

    // randomized command mix against the model
    for (int k = 0; k < 6; k++) begin
      do_uir(2'($urandom_range(0, 3)));
      for (int j = 0; j <= int'($urandom_range(0, 2)); j++) do_udr(rnd38());
      while (mq.size() != 0) pop_chk($sformatf("rnd%0d", k));
    end

    // 5: reset mid-stream with two queued and vs_udr held high
    do_udr(rnd38());
    do_udr(rnd38());
    m_ovf = 1'b1;
    sr = rnd38(); vs_udr = 1'b1;
    tick();
    reset = 1'b1; #1;
    mq.delete(); m_ir = 0; m_ovf = 0; m_cnt = 0;
    chk("t5_valid", 64'(cmd_valid), 64'h0);
    chk("t5_ir",    64'(cmd_ir), 64'h0);
    chk("t5_jdo",   64'(jdo), 64'h0);
    chk("t5_act",   64'(cmd_act), 64'h0);
    chk("t5_ta",    64'(take_action), 64'h0);
    chk("t5_tna",   64'(take_no_action), 64'h0);
    repeat (2) tick();
    reset = 1'b0;
    repeat (6) tick();
    chk("t5_no_push_high", 64'(cmd_valid), 64'h0);
    vs_udr = 1'b0;
    repeat (4) tick();
    chk("t5_no_push_low", 64'(cmd_valid), 64'h0);
    do_udr(rnd38());
    pop_chk("t5_after");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
